// File: rtl/coin_acceptor.sv
// ============================================================================
// coin_acceptor : sync/debounce of raw coin sensors, single-cycle coin pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 2,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             raw_nickel,
   input  logic             raw_dime,
   input  logic             raw_quarter,
   input  logic             accept_en,
   output logic             nickel,
   output logic             dime,
   output logic             quarter,
   output logic             reject,
   output logic             busy,
   output logic [CNT_W-1:0] coin_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] c_deb_last = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      EMIT    = 3'd2,
      REJECT  = 3'd3,
      RELEASE = 3'd4,
      GAP     = 3'd5
   } state_t;

   state_t          r_state;
   logic [2:0]      r_sync1;
   logic [2:0]      r_sync2;
   logic [2:0]      r_pat;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   r_gcnt;
   logic            w_onehot;
   logic [2:0]      w_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= {raw_quarter, raw_dime, raw_nickel};
         r_sync2 <= r_sync1;
      end
   end

   assign w_s      = r_sync2;
   assign w_onehot = ((r_pat & (r_pat - 3'd1)) == 3'd0) && (r_pat != 3'd0);

   // Reset lands in RELEASE so a coin held through reset must be seen gone first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RELEASE;
         r_pat      <= 3'b000;
         r_cnt      <= '0;
         r_gcnt     <= '0;
         nickel     <= 1'b0;
         dime       <= 1'b0;
         quarter    <= 1'b0;
         reject     <= 1'b0;
         busy       <= 1'b0;
         coin_count <= '0;
      end else begin
         nickel  <= 1'b0;
         dime    <= 1'b0;
         quarter <= 1'b0;
         reject  <= 1'b0;
         busy    <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_s != 3'b000) begin
                  r_pat   <= w_s;
                  r_cnt   <= '0;
                  r_state <= SETTLE;
               end else begin
                  busy <= 1'b0;
               end
            end
            SETTLE: begin
               if (w_s != r_pat) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else if (r_cnt == c_deb_last) begin
                  if (w_onehot && accept_en) begin
                     r_state    <= EMIT;
                     nickel     <= r_pat[0];
                     dime       <= r_pat[1];
                     quarter    <= r_pat[2];
                     coin_count <= coin_count + CNT_W'(1);
                  end else begin
                     r_state <= REJECT;
                     reject  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            EMIT, REJECT: begin
               r_state <= RELEASE;
               r_cnt   <= '0;
            end
            RELEASE: begin
               if (w_s != 3'b000) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_deb_last) begin
                  r_state <= GAP;
                  r_cnt   <= '0;
                  r_gcnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            GAP: begin
               if (r_gcnt == c_gap_last) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  r_gcnt <= r_gcnt + GW'(1);
               end
            end
            default: begin
               r_state <= RELEASE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
